// File: rtl/sync_fifo_param.sv
// Parametrised single-clock show-ahead FIFO for the pixel line buffer.
// Status and count come straight from the registered wrap-bit pointers.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam logic [AW:0] AF_LVL = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_LVL = (AW+1)'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic              rd_en;
  logic              wr_en;

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[AW] != rptr[AW]) &&
                      (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count        = wptr - rptr;
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);
  assign data_out     = fifo_empty ? '0 : mem[rptr[AW-1:0]];

  // A full FIFO still takes a write when the head is popped the same cycle
  assign rd_en = rd & ~fifo_empty;
  assign wr_en = wr & (~fifo_full | rd_en);

  always_ff @(posedge clk) begin
    if (rst_n && wr_en)
      mem[wptr[AW-1:0]] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en)
        wptr <= wptr + 1'b1;
      if (rd_en)
        rptr <= rptr + 1'b1;
      // A new error event wins over a clear in the same cycle
      if (wr && !wr_en)
        overflow <= 1'b1;
      else if (clr_err)
        overflow <= 1'b0;
      if (rd && !rd_en)
        underflow <= 1'b1;
      else if (clr_err)
        underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: queue model checked every cycle,
// directed scenarios with literal expectations, then random traffic.
module tb_sync_fifo_param;

  localparam int DW = 8;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr;
  logic [DW-1:0] data_in;
  logic          rd;
  logic          clr_err;
  logic [DW-1:0] data_out;
  logic          fifo_full;
  logic          fifo_empty;
  logic          almost_full;
  logic          almost_empty;
  logic [4:0]    count;
  logic          overflow;
  logic          underflow;

  int n_pass = 0;
  int n_chk  = 0;

  logic [DW-1:0] q[$];
  bit            m_ovf;
  bit            m_udf;
  bit            known = 0;

  sync_fifo_param #(
    .DATA_W(DW), .DEPTH(DP), .AF_THRESH(14), .AE_THRESH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .data_in(data_in),
    .rd(rd), .data_out(data_out), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  // Reference model: occupancy is the queue, errors are two bits
  always @(posedge clk) begin
    bit re, we;
    if (!rst_n) begin
      q.delete();
      m_ovf = 0;
      m_udf = 0;
      known = 1;
    end else if (known) begin
      re = rd && (q.size() > 0);
      we = wr && ((q.size() < DP) || re);
      if (wr && !we) m_ovf = 1;
      else if (clr_err) m_ovf = 0;
      if (rd && !re) m_udf = 1;
      else if (clr_err) m_udf = 0;
      if (re) void'(q.pop_front());
      if (we) q.push_back(data_in);
    end
  end

  always @(negedge clk) begin
    int n;
    if (known) begin
      n = q.size();
      chk("count", int'(count), n);
      chk("full", int'(fifo_full), int'(n == DP));
      chk("empty", int'(fifo_empty), int'(n == 0));
      chk("afull", int'(almost_full), int'(n >= 14));
      chk("aempty", int'(almost_empty), int'(n <= 2));
      chk("dout", int'(data_out), n > 0 ? int'(q[0]) : 0);
      chk("ovf", int'(overflow), int'(m_ovf));
      chk("udf", int'(underflow), int'(m_udf));
    end
  end

  task automatic cyc(input bit w, input logic [DW-1:0] d,
                     input bit r, input bit c, input bit rn);
    wr      = w;
    data_in = d;
    rd      = r;
    clr_err = c;
    rst_n   = rn;
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] v;
    cyc(0, 0, 0, 0, 0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(fifo_empty), 1);
    chk("rst_aempty", int'(almost_empty), 1);
    chk("rst_dout", int'(data_out), 0);

    for (int i = 0; i < 16; i++) begin
      cyc(1, DW'(i), 0, 0, 1);
      chk("fill_count", int'(count), i + 1);
      chk("fill_dout", int'(data_out), 0);
      chk("fill_af", int'(almost_full), int'(i + 1 >= 14));
    end
    chk("fill_full", int'(fifo_full), 1);

    cyc(1, 8'hAA, 0, 0, 1);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_count", int'(count), 16);
    cyc(0, 0, 0, 1, 1);
    chk("ovf_clr", int'(overflow), 0);
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", int'(data_out), i);
      cyc(0, 0, 1, 0, 1);
    end
    chk("drain_empty", int'(fifo_empty), 1);

    for (int i = 0; i < 16; i++) cyc(1, DW'(i), 0, 0, 1);
    cyc(1, 8'h55, 1, 0, 1);
    chk("rw_full_count", int'(count), 16);
    chk("rw_full_ovf", int'(overflow), 0);
    chk("rw_full_dout", int'(data_out), 1);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("rw_last", int'(data_out), 8'h55);
      cyc(0, 0, 1, 0, 1);
    end

    cyc(0, 0, 1, 0, 1);
    chk("udf_set", int'(underflow), 1);
    chk("udf_count", int'(count), 0);
    chk("udf_dout", int'(data_out), 0);
    cyc(0, 0, 0, 1, 1);
    chk("udf_clr", int'(underflow), 0);
    cyc(1, 8'h3C, 1, 0, 1);
    chk("er_count", int'(count), 1);
    chk("er_dout", int'(data_out), 8'h3C);
    chk("er_udf", int'(underflow), 1);
    cyc(0, 0, 1, 1, 1);

    for (int i = 0; i < 8; i++) cyc(1, 8'($urandom), 0, 0, 1);
    for (int i = 0; i < 40; i++) begin
      v = 8'($urandom);
      cyc(1, v, 1, 0, 1);
      chk("stream_count", int'(count), 8);
    end
    cyc(1, 8'h99, 0, 0, 1);
    chk("pre_rst_count", int'(count), 9);
    cyc(1, 8'h77, 1, 0, 0);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_empty", int'(fifo_empty), 1);
    chk("mid_rst_aempty", int'(almost_empty), 1);
    chk("mid_rst_afull", int'(almost_full), 0);
    chk("mid_rst_err", int'({overflow, underflow}), 0);
    chk("mid_rst_dout", int'(data_out), 0);

    for (int i = 0; i < 2000; i++) begin
      int bias;
      bias = (i / 250) % 2 == 0 ? 70 : 30;
      cyc($urandom_range(99) < bias, 8'($urandom),
          $urandom_range(99) < 100 - bias,
          $urandom_range(99) < 5,
          $urandom_range(199) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO. It is the next-generation line buffer for the image-processing datapath, replacing the fixed 8-bit x 16 FIFO.
- Adds configurable width and depth, fill count, almost-full/almost-empty thresholds, and sticky overflow/underflow error flags with clear.
- Supports read+write in the same cycle when full.
- Sits between pixel producers (DMA/line fetch) and filter kernels.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries. Power of two, >=4.
- AF_THRESH, 14, almost_full asserts when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1).
- Derived: AW = log2(DEPTH). Pointers are AW+1 bits, the MSB being the wrap bit.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- wr  in  1  write request.
- data_in  in  DATA_W  write data, sampled on the clk edge when the write is accepted.
- rd  in  1  read request; pops the current head word.
- data_out  out  DATA_W  head-of-queue word (show-ahead).
- fifo_full  out  1  count == DEPTH.
- fifo_empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.
- clr_err  in  1  clears overflow and underflow.

Behaviour:
- Reset: sampled on the clk edge while rst_n=0. It overrides all other inputs, including mid-burst.
  - wptr=0, rptr=0, overflow=0, underflow=0.
  - Resulting outputs: count=0, fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0 (given AF_THRESH>=1), data_out=0.
  - Memory contents are not reset.
- Accept rules, evaluated from the current registered state:
  - rd_en = rd & ~fifo_empty.
  - wr_en = wr & (~fifo_full | rd_en). A write to a full FIFO is accepted if a read is accepted in the same cycle.
  - Empty + wr + rd: the write is accepted and the read is rejected (no fall-through in the same cycle). underflow sets.
- Pointers:
  - wr_en writes mem[wptr[AW-1:0]] <= data_in, then wptr <= wptr+1.
  - rd_en sets rptr <= rptr+1.
  - Both pointers wrap modulo 2*DEPTH through natural AW+1-bit rollover.
- Status:
  - count = wptr - rptr (AW+1-bit modular subtraction).
  - fifo_full when the wrap bits differ and the low AW bits are equal.
  - fifo_empty when wptr == rptr.
  - All flags and count are combinational from the registered pointers, so they reflect an accepted op one cycle after the edge. Latency from write to visible count/flags is 1 clk.
- Data out:
  - data_out = mem[rptr[AW-1:0]] when ~fifo_empty, else 0.
  - A word written at edge N is visible on data_out after edge N if the FIFO was empty.
- Simultaneous rd_en & wr_en: count is unchanged and both pointers advance. Valid at full, partially full, and across the wrap boundary.
- Error flags:
  - overflow sets on wr & ~wr_en; underflow sets on rd & ~rd_en.
  - Set has priority over clr_err in the same cycle; otherwise clr_err clears both flags.
  - Rejected ops never change pointers or memory.
- Ordering: strict FIFO order across any number of wraps.

Test Plan:
- Reset, then 16 writes of 0x00..0x0F (DEPTH=16), no reads.
  - Required: count steps 1..16; almost_full rises on the cycle count=14; fifo_full=1 at 16; fifo_empty=0 after the first write; data_out=0x00 throughout.
- Full FIFO, then wr=1 with data 0xAA and rd=0.
  - Required: overflow=1 next cycle; count stays 16; subsequent 16 reads return 0x00..0x0F in order.
- Full FIFO, then wr=1 (0x55) and rd=1 in the same cycle.
  - Required: write accepted; count stays 16; overflow stays 0; data_out becomes 0x01; 0x55 is the 16th word read back.
- Empty FIFO, then rd=1 alone.
  - Required: underflow=1; count=0; data_out=0.
  - Then clr_err=1: underflow=0.
  - Then wr=1 (0x3C) and rd=1 together: count=1, data_out=0x3C, underflow=1.
- Continuous stream of 40 words at count ~8 with simultaneous rd/wr (pointers wrap twice).
  - Required: output sequence equals input sequence with no loss; count constant; no error flags.
- rst_n=0 for one cycle with count=9 mid-burst.
  - Required: next cycle count=0, fifo_empty=1, almost_empty=1, almost_full=0, overflow=underflow=0, data_out=0.
